// File: rtl/hamming_secded_serial_decoder_pkg.sv
// Shared Hamming code geometry helpers and the decoder's enum types.
package hamming_pkg;

  typedef enum logic [1:0] {CLEAN, CORR, UNCORR} err_class_e;
  typedef enum logic {EMPTY, FULL} slot_state_e;

  function automatic int unsigned n_of(input int unsigned r);
    return (1 << r) - 1;
  endfunction

  function automatic int unsigned k_of(input int unsigned r);
    return n_of(r) - r;
  endfunction

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Code position holding data bit idx (idx-th non-power position, ascending).
  function automatic int unsigned data_pos(input int unsigned r, input int unsigned idx);
    int unsigned cnt = 0;
    for (int unsigned p = 1; p <= n_of(r); p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) return p;
        cnt++;
      end
    end
    return 0;
  endfunction

  // Data index carried by a non-power code position.
  function automatic int unsigned pos_to_data(input int unsigned pos);
    int unsigned cnt = 0;
    for (int unsigned p = 1; p < pos; p++) begin
      if (!is_pow2(p)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hamming_secded_serial_decoder_syndrome.sv
// Combinational Hamming/SECDED check: syndrome, overall parity, corrected data, class.
module hamming_syndrome_calc
  import hamming_pkg::*;
#(
  parameter int unsigned R   = 4,
  parameter int unsigned EXT = 1
) (
  input  logic [n_of(R)+EXT-1:0] cw,
  output logic [R-1:0]           syndrome_c,
  output logic                   parity_c,
  output logic [k_of(R)-1:0]     data_c,
  output err_class_e             err_class_c
);

  localparam int unsigned N = n_of(R);
  localparam int unsigned K = k_of(R);

  logic [N:1] pos;
  logic       flip;

  // cw bit EXT+p-1 carries position p; bit 0 is the ext bit when present.
  always_comb begin
    syndrome_c = '0;
    for (int unsigned p = 1; p <= N; p++) begin
      if (cw[EXT+p-1]) syndrome_c = syndrome_c ^ R'(p);
    end
    parity_c = (EXT != 0) ? ^cw : 1'b0;
    flip     = (syndrome_c != '0) && ((EXT == 0) || parity_c);
    for (int unsigned p = 1; p <= N; p++) begin
      pos[p] = cw[EXT+p-1] ^ (flip && (syndrome_c == R'(p)));
    end
    if ((EXT != 0) && (syndrome_c != '0) && !parity_c) err_class_c = UNCORR;
    else if ((syndrome_c != '0) || parity_c)           err_class_c = CORR;
    else                                               err_class_c = CLEAN;
  end

  for (genvar i = 0; i < K; i++) begin : g_data
    assign data_c[i] = pos[data_pos(R, i)];
  end

endmodule

// File: rtl/hamming_secded_serial_decoder.sv
// Serial Hamming SEC/SECDED decoder: bit collection, one-deep pending word,
// valid/ready output slot with overrun flag and saturating error counters.
module hamming_secded_serial_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned R         = 4,
  parameter int unsigned EXT       = 1,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 REST,
  input  logic                 DEVICE_EN,
  input  logic                 BIT_STB,
  input  logic                 SERIAL_IN,
  output logic [k_of(R)-1:0]   DATA_OUT,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 CORRECTED,
  output logic                 UNCORRECTABLE,
  output logic [R-1:0]         SYNDROME,
  output logic                 OVERRUN,
  output logic [CNT_W-1:0]     COR_CNT,
  output logic [CNT_W-1:0]     UNC_CNT
);

  localparam int unsigned N   = n_of(R);
  localparam int unsigned K   = k_of(R);
  localparam int unsigned W   = N + EXT;
  localparam int unsigned BCW = $clog2(W);

  slot_state_e    state;
  logic [W-1:0]   sr, sr_next, cw_reg;
  logic [BCW-1:0] bit_cnt;
  logic           pend;

  logic [R-1:0]   syn_c;
  logic           par_c;
  logic [K-1:0]   dec_data_c;
  err_class_e     cls_c;

  logic strobe_c, last_bit_c, word_done_c, load_c;

  // Both bit orders land position p at sr bit EXT+p-1 once the word is complete.
  always_comb begin
    if (MSB_FIRST != 0) sr_next = {sr[W-2:0], SERIAL_IN};
    else                sr_next = {SERIAL_IN, sr[W-1:1]};
  end

  assign strobe_c    = BIT_STB && DEVICE_EN;
  assign last_bit_c  = (bit_cnt == BCW'(W - 1));
  assign word_done_c = strobe_c && last_bit_c;
  assign load_c      = pend && ((state == EMPTY) || DATA_READY);

  hamming_syndrome_calc #(.R(R), .EXT(EXT)) u_syndrome (
    .cw          (cw_reg),
    .syndrome_c  (syn_c),
    .parity_c    (par_c),
    .data_c      (dec_data_c),
    .err_class_c (cls_c)
  );

  always_ff @(posedge CLK) begin
    if (REST) begin
      state         <= EMPTY;
      sr            <= '0;
      cw_reg        <= '0;
      bit_cnt       <= '0;
      pend          <= 1'b0;
      DATA_OUT      <= '0;
      DATA_VALID    <= 1'b0;
      CORRECTED     <= 1'b0;
      UNCORRECTABLE <= 1'b0;
      SYNDROME      <= '0;
      OVERRUN       <= 1'b0;
      COR_CNT       <= '0;
      UNC_CNT       <= '0;
    end else begin
      if (strobe_c) begin
        sr      <= sr_next;
        bit_cnt <= last_bit_c ? '0 : bit_cnt + BCW'(1);
      end

      // A completing word always wins cw_reg; an undelivered older word is dropped.
      if (word_done_c) begin
        cw_reg <= sr_next;
        pend   <= 1'b1;
        if (pend && !load_c) OVERRUN <= 1'b1;
      end else if (load_c) begin
        pend <= 1'b0;
      end

      if (load_c) begin
        state         <= FULL;
        DATA_VALID    <= 1'b1;
        DATA_OUT      <= dec_data_c;
        SYNDROME      <= syn_c;
        CORRECTED     <= (cls_c == CORR);
        UNCORRECTABLE <= (cls_c == UNCORR);
        if ((cls_c == CORR) && (COR_CNT != {CNT_W{1'b1}}))   COR_CNT <= COR_CNT + CNT_W'(1);
        if ((cls_c == UNCORR) && (UNC_CNT != {CNT_W{1'b1}})) UNC_CNT <= UNC_CNT + CNT_W'(1);
      end else if ((state == FULL) && DATA_READY) begin
        state      <= EMPTY;
        DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hamming_secded_serial_decoder.md
Name: hamming_secded_serial_decoder

Overview:
Parametrised serial Hamming decoder. It is the successor to the fixed (15,11) decoder datapath. It runs on a single clock, with a bit strobe replacing the divided clocks, and generalises the code to R parity bits. It adds optional SECDED (an extended overall-parity bit), a valid/ready output handshake with overrun detection, and saturating error counters. It sits between the serial line receiver and the parallel data consumer.

Parameters:
- R, 4: Hamming parity bits. N = 2^R-1 code bits; K = N-R data bits; legal R = 3..6.
- EXT, 1: 1 = extended overall-parity bit appended (SECDED); 0 = plain SEC. W = N+EXT bits per word.
- MSB_FIRST, 1: 1 = position N sent first, position 1 after it, ext bit last. 0 = ext bit first, then position 1 up to position N.
- CNT_W, 16: error-counter width.

Ports:
- CLK, input, 1: the single clock.
- REST, input, 1: synchronous, active-high reset.
- DEVICE_EN, input, 1: block enable; when low, BIT_STB is ignored.
- BIT_STB, input, 1: one-cycle strobe; SERIAL_IN is valid in this cycle.
- SERIAL_IN, input, 1: serial code bit.
- DATA_OUT, output, K: corrected data word.
- DATA_VALID, output, 1: DATA_OUT and its flags are valid.
- DATA_READY, input, 1: consumer accepts the word when DATA_VALID && DATA_READY.
- CORRECTED, output, 1: single error corrected; qualified by DATA_VALID.
- UNCORRECTABLE, output, 1: double error detected; qualified by DATA_VALID; needs EXT=1.
- SYNDROME, output, R: raw syndrome of the delivered word.
- OVERRUN, output, 1: sticky; a pending word was overwritten. Cleared only by REST.
- COR_CNT, output, CNT_W: saturating count of corrected words.
- UNC_CNT, output, CNT_W: saturating count of uncorrectable words.

Behaviour:
- Code layout:
  - Positions 1..N; parity bits sit at power-of-two positions.
  - data[i] occupies the i-th non-power position in ascending order (R=4: data[0]=pos3 … data[10]=pos15).
  - Ext bit gives even parity over all W bits.
- Reset: every output, counter, bit counter, shift register and pending flag is 0, and DATA_VALID=0. REST mid-word discards the partial word.
- Collect:
  - On BIT_STB && DEVICE_EN the bit shifts into the shift register and bit_cnt increments.
  - On the W-th bit, the full word is copied to cw_reg, pend is set and bit_cnt returns to 0.
  - Collection of the next word continues without a gap.
  - DEVICE_EN low freezes bit_cnt and the partial word; it does not affect the output side.
- Decode (combinational on cw_reg):
  - s = XOR of the indices of all set positions.
  - p = XOR of all W bits (p is taken as 0 when EXT=0).
- Classification, EXT=1:
  - s=0, p=0: clean.
  - s≠0, p=1: flip position s; CORRECTED=1.
  - s=0, p=1: ext bit was in error; data is untouched; CORRECTED=1.
  - s≠0, p=0: UNCORRECTABLE=1; data is passed raw.
- Classification, EXT=0: s≠0 means flip position s and CORRECTED=1.
- Output register (states EMPTY/FULL):
  - When pend=1 and the slot is EMPTY, or FULL being accepted this cycle, the decoded result loads into the output register and pend clears.
  - DATA_VALID=1 the following cycle, i.e. 2 CLK after the strobe of the last bit.
  - Output data and flags hold stable while DATA_VALID && !DATA_READY.
  - Acceptance without a new load returns the slot to EMPTY.
  - Back-to-back words with DATA_READY held high stream out with no lost words.
- Overrun:
  - Trigger: a new word completes while pend=1 and no load occurs that same cycle.
  - Response: cw_reg takes the new word (the older word is dropped) and OVERRUN sets.
- Counters:
  - COR_CNT or UNC_CNT increments in the cycle the output register loads a flagged word.
  - Both saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Package hamming_pkg holds:
  - functions n_of(R) and k_of(R);
  - is_pow2(pos);
  - the position-to-data-index map functions;
  - an error-class enum {CLEAN, CORR, UNCORR}.
- One sub-module, hamming_syndrome_calc: combinational cw→{s, p, corrected data, class}. It is reused later by the encoder check path.

Test Plan:
All scenarios use R=4, EXT=1, MSB_FIRST=1 with BIT_STB every 11 CLK.
1. Sixteen 1 bits → DATA_OUT=11'h7FF, SYNDROME=0, CORRECTED=0, UNCORRECTABLE=0, DATA_VALID 2 CLK after the 16th strobe.
2. All-zero word with pos6 flipped → SYNDROME=6, CORRECTED=1, DATA_OUT=0, COR_CNT=1.
3. All-zero word with pos3 and pos5 flipped → SYNDROME=6, UNCORRECTABLE=1, DATA_OUT=11'h003 (raw), UNC_CNT=1.
4. All-ones word with the ext bit sent as 0 → SYNDROME=0, CORRECTED=1, DATA_OUT=11'h7FF.
5. Three words with DATA_READY=0 throughout → first word held stable, second pending, third completes → OVERRUN=1. After DATA_READY=1: word1 then word3 are delivered; word2 is lost.
6. REST pulsed after 7 bits, then the all-ones stream sent → all outputs 0 during reset; first delivered word is 11'h7FF with no flags. DEVICE_EN low for 3 strobes mid-word → those bits are ignored and the word decodes correctly.
